regfile_sb: RTL

Parametrised integer register file with a per-register scoreboard, N combinational read ports, one write port with optional same-cycle write-to-read bypass, and a sequenced bulk-clear engine.
Serves as the next-generation register file for the pipelined/multicycle core.
Decode reserves destinations, writeback releases them, and the hazard unit reads per-port busy flags.
Register 0 is hardwired zero.

---
 rtl/regfile_sb_pkg.sv | 8 +
 rtl/regfile_sb_clr_fsm.sv | 49 ++++
 rtl/regfile_sb.sv | 81 ++++++++
 3 files changed

// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared types, constants and address-width helper for regfile_sb
package regfile_sb_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_e;
  localparam int REG_ZERO = 0;
  function automatic int addr_width(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/regfile_sb_clr_fsm.sv
// regfile_sb_clr_fsm: sequences the bulk clear one register per cycle, from index 1 up to NREGS-1
module regfile_sb_clr_fsm
  import regfile_sb_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          clear_active,
  output logic [AW-1:0] clear_idx,
  output logic          clr_busy,
  output logic          clr_done
);
  clr_state_e state;
  logic [AW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (clr_req) begin
          state    <= CLEAR;
          cnt      <= AW'(1);
          clr_busy <= 1'b1;
        end
        CLEAR: begin
          cnt <= cnt + AW'(1);
          if (cnt == AW'(NREGS - 1)) begin
            state    <= DONE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end
  assign clear_active = clr_busy;
  assign clear_idx    = cnt;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with per-register busy scoreboard, N read ports, write bypass and bulk clear
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter bit BYPASS = 1'b1,
  localparam int AW = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                res_en,
  input  logic [AW-1:0]       res_addr,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done
);
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic clear_active;
  logic [AW-1:0] clear_idx;
  logic wr_ok;

  regfile_sb_clr_fsm #(.NREGS(NREGS), .AW(AW)) u_clr (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_req      (clr_req),
    .clear_active (clear_active),
    .clear_idx    (clear_idx),
    .clr_busy     (clr_busy),
    .clr_done     (clr_done)
  );

  // Full-width compare so out-of-range addresses never alias for non-power-of-two NREGS
  assign wr_ok = wr_en && wr_addr != AW'(REG_ZERO) && 32'(wr_addr) < 32'(NREGS);

  // Register 0 is only ever written by reset, so it stays zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      for (int i = REG_ZERO + 1; i < NREGS; i++) begin
        if (clear_active) begin
          if (clear_idx == AW'(i)) begin
            regs[i] <= '0;
            busy[i] <= 1'b0;
          end
        end else begin
          if (wr_en && wr_addr == AW'(i)) regs[i] <= wr_data;
          if (res_en && res_addr == AW'(i)) busy[i] <= 1'b1;
          else if (wr_en && wr_addr == AW'(i)) busy[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      for (int i = REG_ZERO + 1; i < NREGS; i++) begin
        if (rd_addr[k*AW +: AW] == AW'(i)) begin
          rd_data[k*XLEN +: XLEN] = regs[i];
          rd_busy[k] = busy[i];
        end
      end
      if (BYPASS && !clear_active && wr_ok && wr_addr == rd_addr[k*AW +: AW]) begin
        rd_data[k*XLEN +: XLEN] = wr_data;
        rd_busy[k] = 1'b0;
      end
    end
  end
endmodule
